// File: rtl/stone_renderer.sv
// stone_renderer: on each frame_start, sweeps every stone RAM slot and rasterises
// each visible stone as a filled square, one pixel per valid/ready handshake.
// Ports:
//   clock, reset (async, active-high)
//   frame_start           one-cycle redraw request (ignored while busy)
//   data[31:0]            RAM record at draw_index, RD_LAT clocks after the index
//   plot_ready            pixel consumer accepts the pixel this cycle
//   draw_stone_flag       RAM port owned by this block
//   draw_index[3:0]       RAM slot being read
//   plot, plot_x, plot_y, plot_colour   pixel stream (RGB 3:3:3)
//   busy, done            sweep in progress / end-of-sweep pulse
module stone_renderer #(
    parameter int NUM_STONES = 16,
    parameter int RD_LAT     = 1,
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [31:0]                   data,
    input  logic                          plot_ready,
    output logic                          draw_stone_flag,
    output logic [$clog2(NUM_STONES)-1:0] draw_index,
    output logic                          plot,
    output logic [9:0]                    plot_x,
    output logic [9:0]                    plot_y,
    output logic [8:0]                    plot_colour,
    output logic                          busy,
    output logic                          done
);

    localparam int IW = $clog2(NUM_STONES);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_DRAW,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [WW-1:0] wait_cnt;
    logic [9:0]    base_x;
    logic [10:0]   cur_x;
    logic [10:0]   cur_y;
    logic [4:0]    dx;
    logic [4:0]    dy;
    logic [4:0]    size;
    logic [8:0]    colour;

    logic          rec_valid;
    logic [1:0]    rec_type;
    logic [9:0]    rec_x;
    logic [9:0]    rec_y;
    logic [4:0]    rec_size;
    logic          unused_rec_bits;

    assign rec_valid       = data[31];
    assign rec_type        = data[30:29];
    assign rec_x           = data[28:19];
    assign rec_y           = data[18:9];
    assign rec_size        = data[8:4];
    assign unused_rec_bits = ^data[3:0];

    logic        last_col;
    logic        last_row;
    logic        advance;
    logic        last_slot;
    logic        wait_end;
    logic [10:0] nxt_x;
    logic [10:0] nxt_y;
    logic [8:0]  rec_colour;

    function automatic logic in_bounds(input logic [10:0] x, input logic [10:0] y);
        return (x < 11'(SCREEN_W)) && (y < 11'(SCREEN_H));
    endfunction

    always_comb begin
        rec_colour = 9'b111_110_000;
        unique case (rec_type)
            2'b00: rec_colour = 9'b111_110_000;
            2'b01: rec_colour = 9'b100_100_100;
            2'b10: rec_colour = 9'b011_111_111;
            2'b11: rec_colour = 9'b110_011_001;
        endcase
    end

    assign last_col  = (dx == size - 5'd1);
    assign last_row  = (dy == size - 5'd1);
    // An off-screen pixel has plot=0 and is skipped in a single cycle.
    assign advance   = (state == S_DRAW) && (!plot || plot_ready);
    assign last_slot = (draw_index == IW'(NUM_STONES - 1));
    assign wait_end  = (wait_cnt == WW'(RD_LAT - 1));
    assign nxt_x     = last_col ? {1'b0, base_x} : cur_x + 11'd1;
    assign nxt_y     = last_col ? cur_y + 11'd1 : cur_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        draw_stone_flag = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (frame_start) state_nx = S_ADDR;
            end
            S_ADDR: begin
                draw_stone_flag = 1'b1;
                busy            = 1'b1;
                state_nx        = S_WAIT;
            end
            S_WAIT: begin
                draw_stone_flag = 1'b1;
                busy            = 1'b1;
                if (wait_end) state_nx = S_LATCH;
            end
            S_LATCH: begin
                draw_stone_flag = 1'b1;
                busy            = 1'b1;
                if (!rec_valid || rec_size == 5'd0) state_nx = S_NEXT;
                else                                state_nx = S_DRAW;
            end
            S_DRAW: begin
                draw_stone_flag = 1'b1;
                busy            = 1'b1;
                if (advance && last_col && last_row) state_nx = S_NEXT;
            end
            S_NEXT: begin
                draw_stone_flag = 1'b1;
                busy            = 1'b1;
                state_nx        = last_slot ? S_DONE : S_ADDR;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt   <= '0;
            draw_index <= '0;
            base_x     <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            dx         <= '0;
            dy         <= '0;
            size       <= '0;
            colour     <= '0;
            plot       <= 1'b0;
        end else begin
            if (state == S_ADDR)      wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + WW'(1);

            if (state == S_IDLE && frame_start)  draw_index <= '0;
            else if (state == S_NEXT && !last_slot) draw_index <= draw_index + IW'(1);

            if (state == S_LATCH) begin
                base_x <= rec_x;
                cur_x  <= {1'b0, rec_x};
                cur_y  <= {1'b0, rec_y};
                size   <= rec_size;
                colour <= rec_colour;
                dx     <= '0;
                dy     <= '0;
                plot   <= rec_valid && (rec_size != 5'd0)
                          && in_bounds({1'b0, rec_x}, {1'b0, rec_y});
            end else if (advance) begin
                if (last_col && last_row) begin
                    plot <= 1'b0;
                end else begin
                    cur_x <= nxt_x;
                    cur_y <= nxt_y;
                    dx    <= last_col ? 5'd0 : dx + 5'd1;
                    dy    <= last_col ? dy + 5'd1 : dy;
                    plot  <= in_bounds(nxt_x, nxt_y);
                end
            end
        end
    end

    // plot=1 implies the coordinate is below the screen size, so bit 10 is zero.
    assign plot_x      = cur_x[9:0];
    assign plot_y      = cur_y[9:0];
    assign plot_colour = colour;

endmodule

// File: tb/tb_stone_renderer.sv
// Testbench for stone_renderer: RAM model, pixel consumer and a nested-loop
// reference rasteriser; directed and randomised sweeps.
module tb_stone_renderer;

    logic        clock;
    logic        reset;
    logic        frame_start;
    logic [31:0] data;
    logic        plot_ready;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic        plot;
    logic [9:0]  plot_x;
    logic [9:0]  plot_y;
    logic [8:0]  plot_colour;
    logic        busy;
    logic        done;

    stone_renderer dut (
        .clock           (clock),
        .reset           (reset),
        .frame_start     (frame_start),
        .data            (data),
        .plot_ready      (plot_ready),
        .draw_stone_flag (draw_stone_flag),
        .draw_index      (draw_index),
        .plot            (plot),
        .plot_x          (plot_x),
        .plot_y          (plot_y),
        .plot_colour     (plot_colour),
        .busy            (busy),
        .done            (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [16];
    logic [8:0]  ctab [4];
    logic [28:0] captured [$];
    logic [28:0] expq [$];
    logic [15:0] visited;
    logic [28:0] prev_pix;
    bit          prev_stall;
    int          done_cnt;
    int          hs_cnt;
    int          stall_cnt;
    int          stall_left;
    int          plot_seen;
    int          rmode;
    bit          trig;

    // Synchronous RAM with one clock of read latency.
    always @(posedge clock) data <= mem[draw_index];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pixel consumer: mode 0 always ready, 1 random, 2 stall 5 cycles after 2nd pixel.
    always @(posedge clock) begin
        #1;
        if (rmode == 1) begin
            plot_ready = ($urandom_range(0, 3) != 0);
        end else if (rmode == 2) begin
            if (!trig && hs_cnt == 2) begin
                trig = 1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                plot_ready = 1'b0;
                stall_left--;
            end else begin
                plot_ready = 1'b1;
            end
        end else begin
            plot_ready = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (plot) plot_seen++;
            if (prev_stall)
                chk("hold", {2'b0, plot, plot_x, plot_y, plot_colour},
                    {2'b0, 1'b1, prev_pix});
            if (plot && plot_ready) begin
                captured.push_back({plot_x, plot_y, plot_colour});
                hs_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("flag_at_done", {31'b0, draw_stone_flag}, 32'd0);
            end
            if (draw_stone_flag) visited[draw_index] = 1'b1;
            prev_stall = plot && !plot_ready;
            if (prev_stall) stall_cnt++;
            prev_pix = {plot_x, plot_y, plot_colour};
        end
    end

    function automatic logic [31:0] rec(input bit v, input int t, input int x,
                                        input int y, input int s);
        logic [31:0] r;
        r = {v, 2'(t), 10'(x), 10'(y), 5'(s), 4'($urandom_range(0, 15))};
        return r;
    endfunction

    task automatic build_exp();
        expq.delete();
        for (int s = 0; s < 16; s++) begin
            logic [31:0] r;
            int x0, y0, sz;
            r  = mem[s];
            x0 = int'(r[28:19]);
            y0 = int'(r[18:9]);
            sz = int'(r[8:4]);
            if (r[31]) begin
                for (int j = 0; j < sz; j++)
                    for (int i = 0; i < sz; i++)
                        if (x0 + i < 320 && y0 + j < 240)
                            expq.push_back({10'(x0 + i), 10'(y0 + j), ctab[r[30:29]]});
            end
        end
    endtask

    task automatic clear_mem();
        for (int s = 0; s < 16; s++) mem[s] = rec(0, 0, 0, 0, 0);
    endtask

    task automatic sweep(input int mode, input bit second_fs, input string tag);
        int cyc;
        int n;
        build_exp();
        captured.delete();
        done_cnt  = 0;
        visited   = '0;
        stall_cnt = 0;
        hs_cnt    = 0;
        trig      = 0;
        stall_left = 0;
        rmode     = mode;
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
        chk({tag, "_start"}, {26'b0, draw_stone_flag, busy, draw_index},
            {26'b0, 1'b1, 1'b1, 4'd0});
        if (second_fs) begin
            repeat (10) @(posedge clock);
            #1 frame_start = 1'b1;
            @(posedge clock); #1 frame_start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(posedge clock);
            cyc++;
        end
        chk({tag, "_timeout"}, (cyc < 20000), 32'd1);
        repeat (30) @(posedge clock);
        #1;
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_busy_end"}, {30'b0, busy, draw_stone_flag}, 32'd0);
        chk({tag, "_visited"}, {16'b0, visited}, 32'h0000_FFFF);
        chk({tag, "_idx_hold"}, {28'b0, draw_index}, 32'd15);
        chk({tag, "_npix"}, captured.size(), expq.size());
        n = (captured.size() < expq.size()) ? captured.size() : expq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_pix%0d", tag, i), {3'b0, captured[i]}, {3'b0, expq[i]});
        rmode = 0;
    endtask

    initial begin
        int cyc;
        ctab[0] = 9'b111_110_000;
        ctab[1] = 9'b100_100_100;
        ctab[2] = 9'b011_111_111;
        ctab[3] = 9'b110_011_001;
        reset = 1'b1;
        frame_start = 1'b0;
        plot_ready = 1'b1;
        rmode = 0;
        plot_seen = 0;
        clear_mem();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs", {4'b0, draw_stone_flag, draw_index, plot, plot_x, plot_y,
                           busy, done}, 32'd0);
        chk("reset_colour", {23'b0, plot_colour}, 32'd0);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        chk("idle_outs", {4'b0, draw_stone_flag, draw_index, plot, plot_x, plot_y,
                          busy, done}, 32'd0);
        chk("idle_plots", plot_seen, 32'd0);

        // Single gold stone in slot 3.
        mem[3] = rec(1, 0, 100, 50, 2);
        sweep(0, 0, "slot3");

        // Same stone with a 5-cycle stall on the third pixel.
        sweep(2, 0, "stall");
        chk("stall_cycles", stall_cnt, 32'd5);
        chk("stall_hs", hs_cnt, 32'd4);

        // Bottom-right corner clipping.
        clear_mem();
        mem[0] = rec(1, 2, 318, 238, 4);
        sweep(0, 0, "corner");

        // Invalid / zero-size stones and a second request mid-sweep.
        clear_mem();
        mem[0] = rec(0, 1, 10, 10, 5);
        mem[1] = rec(1, 3, 20, 20, 0);
        sweep(0, 1, "empty");

        // Reset while drawing slot 2.
        clear_mem();
        mem[2] = rec(1, 1, 10, 10, 8);
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
        cyc = 0;
        while (!(plot && draw_index == 4'd2) && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        chk("rst_reach_draw", (cyc < 2000), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async", {29'b0, draw_stone_flag, plot, busy}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        sweep(0, 0, "after_rst");

        // Randomised sweeps.
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 16; s++) begin
                int x, y;
                x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(300, 340))
                                                : int'($urandom_range(0, 319));
                y = ($urandom_range(0, 1) != 0) ? int'($urandom_range(220, 250))
                                                : int'($urandom_range(0, 239));
                mem[s] = rec($urandom_range(0, 1) != 0, $urandom_range(0, 3), x, y,
                             $urandom_range(0, 6));
            end
            sweep(k % 2, 0, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
